multi_ch_debouncer: RTL

Parametrised, multi-channel successor to the single-input debounce checker. It filters NUM_CH asynchronous noisy inputs (buttons, straps, external status lines) into clean synchronous levels. Each channel has a synchroniser, an independent debounce FSM and asymmetric programmable rise/fall thresholds. The block also emits per-channel edge pulses and glitch pulses, and keeps a saturating glitch event counter. It sits between the pad ring and the control/interrupt logic.

---
 rtl/multi_ch_debouncer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multi_ch_debouncer.sv
// Multi-channel input debouncer: per-channel synchroniser, debounce FSM with
// asymmetric rise/fall thresholds, edge/glitch pulses and a saturating glitch counter.
module multi_ch_debouncer #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GLITCH_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   noisy_in,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [CNT_W-1:0]    cfg_rise_thr,
  input  logic [CNT_W-1:0]    cfg_fall_thr,
  input  logic                glitch_clr,
  output logic [NUM_CH-1:0]   clean_out,
  output logic [NUM_CH-1:0]   rise_pulse,
  output logic [NUM_CH-1:0]   fall_pulse,
  output logic [NUM_CH-1:0]   glitch_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned CW1   = CNT_W + 1;
  // Headroom so adding up to 32 events to a saturated count cannot wrap.
  localparam int unsigned SUM_W = GLITCH_W + 6;
  localparam logic [SUM_W-1:0] G_MAX = SUM_W'({GLITCH_W{1'b1}});

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_in;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  thr     [NUM_CH];
  logic [CW1-1:0]    cnt_nx  [NUM_CH];

  logic [NUM_CH-1:0]   clean_d;
  logic [NUM_CH-1:0]   rise_d;
  logic [NUM_CH-1:0]   fall_d;
  logic [NUM_CH-1:0]   glitch_d;
  logic [SUM_W-1:0]    pop;
  logic [SUM_W-1:0]    gsum;
  logic [GLITCH_W-1:0] glitch_cnt_d;

  // Synchroniser chain per channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= noisy_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Live threshold select and widened increment (no overflow in the compare).
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      thr[i]    = ((state_q[i] == STABLE_LO) || (state_q[i] == PEND_HI)) ?
                  cfg_rise_thr : cfg_fall_thr;
      cnt_nx[i] = CW1'(cnt_q[i]) + CW1'(1);
    end
  end

  // Debounce next-state and output logic.
  always_comb begin
    clean_d  = clean_out;
    rise_d   = '0;
    fall_d   = '0;
    glitch_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!ch_en[i]) begin
        state_d[i] = clean_out[i] ? STABLE_HI : STABLE_LO;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          STABLE_LO: begin
            cnt_d[i] = '0;
            if (sync_in[i]) begin
              if (thr[i] <= CNT_W'(1)) begin
                state_d[i] = STABLE_HI;
                clean_d[i] = 1'b1;
                rise_d[i]  = 1'b1;
              end else begin
                state_d[i] = PEND_HI;
                cnt_d[i]   = CNT_W'(1);
              end
            end
          end
          PEND_HI: begin
            if (sync_in[i]) begin
              if (cnt_nx[i] >= CW1'(thr[i])) begin
                state_d[i] = STABLE_HI;
                clean_d[i] = 1'b1;
                rise_d[i]  = 1'b1;
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i] = cnt_nx[i][CNT_W-1:0];
              end
            end else begin
              state_d[i]  = STABLE_LO;
              cnt_d[i]    = '0;
              glitch_d[i] = 1'b1;
            end
          end
          STABLE_HI: begin
            cnt_d[i] = '0;
            if (!sync_in[i]) begin
              if (thr[i] <= CNT_W'(1)) begin
                state_d[i] = STABLE_LO;
                clean_d[i] = 1'b0;
                fall_d[i]  = 1'b1;
              end else begin
                state_d[i] = PEND_LO;
                cnt_d[i]   = CNT_W'(1);
              end
            end
          end
          PEND_LO: begin
            if (!sync_in[i]) begin
              if (cnt_nx[i] >= CW1'(thr[i])) begin
                state_d[i] = STABLE_LO;
                clean_d[i] = 1'b0;
                fall_d[i]  = 1'b1;
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i] = cnt_nx[i][CNT_W-1:0];
              end
            end else begin
              state_d[i]  = STABLE_HI;
              cnt_d[i]    = '0;
              glitch_d[i] = 1'b1;
            end
          end
          default: begin
            state_d[i] = STABLE_LO;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Saturating accumulation of the registered glitch pulses.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pop = pop + SUM_W'(glitch_pulse[i]);
    end
    gsum = SUM_W'(glitch_cnt) + pop;
    if (glitch_clr) begin
      glitch_cnt_d = '0;
    end else if (gsum > G_MAX) begin
      glitch_cnt_d = {GLITCH_W{1'b1}};
    end else begin
      glitch_cnt_d = gsum[GLITCH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= STABLE_LO;
        cnt_q[i]   <= '0;
      end
      clean_out    <= '0;
      rise_pulse   <= '0;
      fall_pulse   <= '0;
      glitch_pulse <= '0;
      glitch_cnt   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clean_out    <= clean_d;
      rise_pulse   <= rise_d;
      fall_pulse   <= fall_d;
      glitch_pulse <= glitch_d;
      glitch_cnt   <= glitch_cnt_d;
    end
  end

endmodule
